// File: rtl/spi_ram_master_if.sv
// Command/SPI bundle for spi_ram_master: request handshake, serial pins, read return.
// master = the serialiser block itself; slave = the host issuing commands plus the SPI target.
// Carries no logic; timing and backpressure are defined by spi_ram_master.
interface spi_ram_master_if #(
  parameter int MEM_WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_cmd;
  logic [MEM_WIDTH-1:0] req_data;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [MEM_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 busy;

  modport master (
    input  req_valid, req_cmd, req_data, MISO,
    output req_ready, SS_n, MOSI, rd_data, rd_valid, busy
  );

  modport slave (
    output req_valid, req_cmd, req_data, MISO,
    input  req_ready, SS_n, MOSI, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/spi_ram_master.sv
// Serialises {cmd,data} RAM commands onto SS_n/MOSI and deserialises 8-bit MISO read replies.
// Latency: SS_n low 11 cycles (writes/rd-addr) or 11+RD_WAIT+MEM_WIDTH cycles (rd-data); rd_valid in STOP.
// Backpressure: req_ready only in IDLE, so one command in flight; requests elsewhere are ignored.
module spi_ram_master #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8,  // must equal MEM_WIDTH: address and data share the payload field
  parameter int RD_WAIT   = 2   // 1..15 turnaround cycles before the first MISO sample
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_master_if.master  bus
);

  localparam int         FRAME_W    = 2 + ADDR_SIZE;
  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] TURN_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] CAP_LAST   = 4'(MEM_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SHIFT   = 3'd2,
    TURN    = 3'd3,
    CAPTURE = 3'd4,
    STOP    = 3'd5
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [FRAME_W-1:0]   frame;
  logic                 rd_frame;
  logic [3:0]           cnt;
  logic [MEM_WIDTH-1:0] cap_sr;
  logic [MEM_WIDTH-1:0] rd_data_q;
  logic                 accept;
  logic                 ss_n_c;
  logic                 mosi_c;
  logic                 ready_c;
  logic                 busy_c;
  logic                 rd_valid_c;
  logic                 cap_done;

  // State register; reset always lands in IDLE regardless of what is in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and pin decode; START repeats the R/W select bit before the full 10-bit shift.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ss_n_c     = 1'b0;
    mosi_c     = 1'b0;
    ready_c    = 1'b0;
    busy_c     = 1'b1;
    rd_valid_c = 1'b0;
    cap_done   = 1'b0;
    case (state)
      IDLE: begin
        ss_n_c  = 1'b1;
        ready_c = 1'b1;
        busy_c  = 1'b0;
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        mosi_c     = frame[FRAME_W-1];
        next_state = SHIFT;
      end
      SHIFT: begin
        mosi_c = frame[FRAME_W-1];
        if (cnt == SHIFT_LAST) next_state = rd_frame ? TURN : STOP;
      end
      TURN: begin
        if (cnt == TURN_LAST) next_state = CAPTURE;
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          cap_done   = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        ss_n_c     = 1'b1;
        rd_valid_c = rd_frame;
        next_state = IDLE;
      end
      default: begin
        ss_n_c     = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  // Frame word: loaded on acceptance, shifted MSB-out once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame    <= '0;
      rd_frame <= 1'b0;
    end else if (accept) begin
      frame    <= {bus.req_cmd, bus.req_data};
      rd_frame <= (bus.req_cmd == 2'b11);
    end else if (state == SHIFT) begin
      frame <= {frame[FRAME_W-2:0], 1'b0};
    end
  end

  // Shared phase counter: restarts on every state change, runs only in timed states.
  always_ff @(posedge clk) begin
    if (rst)                                                   cnt <= '0;
    else if (next_state != state)                              cnt <= '0;
    else if (state == SHIFT || state == TURN || state == CAPTURE) cnt <= cnt + 4'd1;
    else                                                       cnt <= '0;
  end

  // MISO deserialiser; X on MISO during CAPTURE is deliberately passed through unfiltered.
  always_ff @(posedge clk) begin
    if (rst)                   cap_sr <= '0;
    else if (state == CAPTURE) cap_sr <= {cap_sr[MEM_WIDTH-2:0], bus.MISO};
  end

  // Read word publishes on entry to STOP so rd_data and rd_valid coincide; a reset drops a partial word.
  always_ff @(posedge clk) begin
    if (rst)           rd_data_q <= '0;
    else if (cap_done) rd_data_q <= {cap_sr[MEM_WIDTH-2:0], bus.MISO};
  end

  assign bus.SS_n      = ss_n_c;
  assign bus.MOSI      = mosi_c;
  assign bus.req_ready = ready_c;
  assign bus.busy      = busy_c;
  assign bus.rd_valid  = rd_valid_c;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: frame bit order, SS_n windows, read capture, reset abort.
// Inputs driven and outputs sampled on the falling edge, one clock cycle per step.
// Every expected value is derived here from the command, payload and MISO word applied.
module tb_spi_ram_master;
  localparam int RD_WAIT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_rd = 8'h00;

  spi_ram_master_if #(.MEM_WIDTH(8)) bus ();

  spi_ram_master #(.MEM_WIDTH(8), .ADDR_SIZE(8), .RD_WAIT(RD_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full command frame starting at the acceptance cycle T; ends at the first IDLE cycle after STOP.
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] data, input logic [7:0] miso_word,
                           input int rst_at, input logic hold, input logic [1:0] hcmd,
                           input logic [7:0] hdata);
    logic [9:0] f;
    f = {cmd, data};
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_data  = data;
    chk("accept_ready", bus.req_ready, 8'd1);
    chk("accept_ss_high", bus.SS_n, 8'd1);
    step();
    bus.req_valid = hold;
    bus.req_cmd   = hcmd;
    bus.req_data  = hdata;
    chk("start_ss", bus.SS_n, 8'd0);
    chk("start_mosi", bus.MOSI, {7'd0, cmd[1]});
    chk("start_ready", bus.req_ready, 8'd0);
    chk("start_busy", bus.busy, 8'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("shift_ss", bus.SS_n, 8'd0);
      chk("shift_mosi", bus.MOSI, {7'd0, f[9-i]});
      chk("shift_ready", bus.req_ready, 8'd0);
    end
    if (cmd == 2'b11) begin
      for (int i = 0; i < RD_WAIT; i++) begin
        step();
        chk("turn_ss", bus.SS_n, 8'd0);
        chk("turn_mosi", bus.MOSI, 8'd0);
        bus.MISO = 1'bx;
      end
      for (int i = 0; i < 8; i++) begin
        step();
        chk("cap_ss", bus.SS_n, 8'd0);
        chk("cap_mosi", bus.MOSI, 8'd0);
        chk("cap_rd_valid", bus.rd_valid, 8'd0);
        if (i == rst_at) begin
          rst = 1'b1;
          bus.MISO = miso_word[7-i];
          step();
          rst = 1'b0;
          bus.MISO = 1'b0;
          chk("abort_ss", bus.SS_n, 8'd1);
          chk("abort_mosi", bus.MOSI, 8'd0);
          chk("abort_busy", bus.busy, 8'd0);
          chk("abort_rd_valid", bus.rd_valid, 8'd0);
          chk("abort_rd_data", bus.rd_data, exp_rd);
          for (int k = 0; k < 10; k++) begin
            step();
            chk("post_abort_rd_valid", bus.rd_valid, 8'd0);
            chk("post_abort_ss", bus.SS_n, 8'd1);
          end
          chk("post_abort_rd_data", bus.rd_data, exp_rd);
          return;
        end
        bus.MISO = miso_word[7-i];
      end
      step();
      bus.MISO = 1'b0;
      exp_rd = miso_word;
      chk("stop_ss", bus.SS_n, 8'd1);
      chk("stop_rd_valid", bus.rd_valid, 8'd1);
      chk("stop_rd_data", bus.rd_data, exp_rd);
      chk("stop_ready", bus.req_ready, 8'd0);
    end else begin
      step();
      chk("stop_ss", bus.SS_n, 8'd1);
      chk("stop_rd_valid", bus.rd_valid, 8'd0);
      chk("stop_ready", bus.req_ready, 8'd0);
    end
    step();
    chk("idle_ready", bus.req_ready, 8'd1);
    chk("idle_ss", bus.SS_n, 8'd1);
    chk("idle_rd_valid", bus.rd_valid, 8'd0);
    chk("idle_busy", bus.busy, 8'd0);
    chk("idle_rd_data_hold", bus.rd_data, exp_rd);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h00;
    bus.MISO      = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state held across 5 idle cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_ss", bus.SS_n, 8'd1);
      chk("rst_mosi", bus.MOSI, 8'd0);
      chk("rst_ready", bus.req_ready, 8'd1);
      chk("rst_rd_valid", bus.rd_valid, 8'd0);
      chk("rst_busy", bus.busy, 8'd0);
      chk("rst_rd_data", bus.rd_data, 8'h00);
    end

    // Write address A5: bit pattern 0,0,1,0,1,0,0,1,0,1 after a 0 start bit.
    run_frame(2'b00, 8'hA5, 8'h00, -1, 1'b0, 2'b00, 8'h00);

    // Back-to-back: second request held valid, accepted at T+13 after a 2-cycle SS_n gap.
    run_frame(2'b01, 8'h3C, 8'h00, -1, 1'b1, 2'b00, 8'h11);
    run_frame(2'b00, 8'h11, 8'h00, -1, 1'b0, 2'b00, 8'h00);

    // Read aborted by reset in the 3rd capture cycle; rd_data stays 0.
    run_frame(2'b11, 8'h00, 8'hFF, 2, 1'b0, 2'b00, 8'h00);

    // Normal command accepted after the abort.
    run_frame(2'b10, 8'h77, 8'h00, -1, 1'b0, 2'b00, 8'h00);

    // Full read returning C6.
    run_frame(2'b11, 8'h00, 8'hC6, -1, 1'b0, 2'b00, 8'h00);

    // Second read with a different word to confirm rd_data updates.
    run_frame(2'b11, 8'hFF, 8'h3A, -1, 1'b0, 2'b00, 8'h00);

    // A request coinciding with reset must not be accepted.
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h12;
    step();
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    chk("rst_req_ss", bus.SS_n, 8'd1);
    chk("rst_req_busy", bus.busy, 8'd0);
    chk("rst_req_ready", bus.req_ready, 8'd1);
    step();
    chk("rst_req_ss2", bus.SS_n, 8'd1);
    chk("rst_req_busy2", bus.busy, 8'd0);
    exp_rd = bus.rd_data;  // rd_data value after a reset is not constrained here

    // Request held with different cmd/data during a frame does not disturb MOSI; taken on return to IDLE.
    run_frame(2'b10, 8'h5A, 8'h00, -1, 1'b1, 2'b01, 8'hFF);
    run_frame(2'b01, 8'hFF, 8'h00, -1, 1'b0, 2'b00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
